// File: rtl/osc_meas_pkg.sv
// Shared parameters, widths and state encoding for the per-frame waveform measurement engine.
package osc_meas_pkg;

  localparam int unsigned DATA_W    = 12;
  localparam int unsigned N_SAMPLES = 256;
  localparam int unsigned HYST      = 8;
  localparam int unsigned IDX_W     = $clog2(N_SAMPLES);
  localparam int unsigned ACC_W     = DATA_W + IDX_W;
  localparam int unsigned CNT_W     = 8;

  localparam logic [DATA_W-1:0] MID_SCALE = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FINISH
  } meas_state_t;

endpackage

// File: rtl/hyst_crossing_det.sv
// Rising-crossing detector with symmetric hysteresis around a programmable threshold.
module hyst_crossing_det
  import osc_meas_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] thr,
  output logic              cross_c,
  output logic              armed
);

  logic [DATA_W:0]   hi_ext;
  logic [DATA_W-1:0] thr_lo;
  logic [DATA_W-1:0] thr_hi;

  // Hysteresis bounds, clamped to the code range at both ends.
  always_comb begin
    hi_ext = {1'b0, thr} + (DATA_W+1)'(HYST);
    thr_lo = (thr < DATA_W'(HYST)) ? '0 : thr - DATA_W'(HYST);
    thr_hi = hi_ext[DATA_W] ? '1 : hi_ext[DATA_W-1:0];
  end

  // Crossing is combinational so the last sample of a frame is counted in the same cycle.
  always_comb begin
    cross_c = en && armed && (sample >= thr_hi);
  end

  // Arm on a low excursion, disarm when a crossing is counted.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      armed <= 1'b0;
    end else if (en) begin
      if (cross_c) begin
        armed <= 1'b0;
      end else if (sample <= thr_lo) begin
        armed <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/waveform_measure.sv
// Scans one triggered frame and publishes max/min/mean/p2p/crossings/period atomically.
module waveform_measure
  import osc_meas_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data [N_SAMPLES],
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] max_val,
  output logic [DATA_W-1:0] min_val,
  output logic [DATA_W-1:0] mean_val,
  output logic [DATA_W-1:0] p2p_val,
  output logic [CNT_W-1:0]  crossings,
  output logic [IDX_W-1:0]  period_smp
);

  meas_state_t       state;
  meas_state_t       state_nxt;
  logic              clr_c;
  logic              rd_c;

  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] sample_q;
  logic [IDX_W-1:0]  s_idx;
  logic              s_vld;
  logic [DATA_W-1:0] max_r;
  logic [DATA_W-1:0] min_r;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx1;
  logic [IDX_W-1:0]  idx2;
  logic [DATA_W-1:0] thr;

  logic [DATA_W-1:0] max_m;
  logic [DATA_W-1:0] min_m;
  logic [ACC_W-1:0]  acc_m;
  logic [CNT_W-1:0]  cnt_m;
  logic [IDX_W-1:0]  idx1_m;
  logic [IDX_W-1:0]  idx2_m;
  logic [DATA_W:0]   mid_sum;
  logic              cross_c;
  logic              armed;

  hyst_crossing_det u_det (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_c),
    .en      (s_vld),
    .sample  (sample_q),
    .thr     (thr),
    .cross_c (cross_c),
    .armed   (armed)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and control strobes; a start landing on the done cycle is dropped.
  always_comb begin
    state_nxt = state;
    clr_c     = 1'b0;
    rd_c      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !done) begin
          state_nxt = SCAN;
          clr_c     = 1'b1;
        end
      end
      SCAN: begin
        rd_c = 1'b1;
        if (idx == IDX_W'(N_SAMPLES - 1)) begin
          state_nxt = FINISH;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Running statistics merged with the sample currently in the read register.
  always_comb begin
    max_m  = max_r;
    min_m  = min_r;
    acc_m  = acc;
    cnt_m  = cnt;
    idx1_m = idx1;
    idx2_m = idx2;
    if (s_vld) begin
      if (sample_q > max_r) max_m = sample_q;
      if (sample_q < min_r) min_m = sample_q;
      acc_m = acc + ACC_W'(sample_q);
    end
    if (cross_c) begin
      if (cnt != '1) cnt_m = cnt + CNT_W'(1);
      if (cnt == CNT_W'(0)) idx1_m = s_idx;
      if (cnt == CNT_W'(1)) idx2_m = s_idx;
    end
    mid_sum = {1'b0, max_m} + {1'b0, min_m};
  end

  // Registered sample read plus scan accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      sample_q <= '0;
      s_idx    <= '0;
      s_vld    <= 1'b0;
      max_r    <= '0;
      min_r    <= '1;
      acc      <= '0;
      cnt      <= '0;
      idx1     <= '0;
      idx2     <= '0;
    end else begin
      s_vld <= rd_c;
      if (rd_c) begin
        sample_q <= data[idx];
        s_idx    <= idx;
      end
      if (clr_c) begin
        idx   <= '0;
        max_r <= '0;
        min_r <= '1;
        acc   <= '0;
        cnt   <= '0;
        idx1  <= '0;
        idx2  <= '0;
      end else begin
        if (rd_c) idx <= idx + IDX_W'(1);
        max_r <= max_m;
        min_r <= min_m;
        acc   <= acc_m;
        cnt   <= cnt_m;
        idx1  <= idx1_m;
        idx2  <= idx2_m;
      end
    end
  end

  // Result publication and next-frame threshold, all on the FINISH edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      max_val    <= '0;
      min_val    <= '0;
      mean_val   <= '0;
      p2p_val    <= '0;
      crossings  <= '0;
      period_smp <= '0;
      thr        <= MID_SCALE;
    end else begin
      done <= (state == FINISH);
      busy <= (state_nxt != IDLE) || (state == FINISH);
      if (state == FINISH) begin
        max_val    <= max_m;
        min_val    <= min_m;
        mean_val   <= DATA_W'(acc_m >> IDX_W);
        p2p_val    <= max_m - min_m;
        crossings  <= cnt_m;
        period_smp <= (cnt_m >= CNT_W'(2)) ? idx2_m - idx1_m : '0;
        thr        <= DATA_W'(mid_sum >> 1);
      end
    end
  end

endmodule
